risc8_fetch: RTL and testbench
==============================

# risc8_fetch

Byte-serial instruction prefetch stage for the risc8 core. Streams opcode and immediate bytes from the single-port program ROM into a small circular byte buffer and presents up to four head bytes (opcode plus up to three immediates) to the control/decode stage. Decode reports the decoded instruction length in `isize` and pops that many bytes. Branch, call, and return redirects flush the buffer and restart fetch at a new address.

## Interface
- `DEPTH`, 8: buffer capacity in bytes; power of two, at least 4.
- `ADDR_W`, 16: program address width.
- `RESET_VEC`, 0: program address fetched after reset.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rom_rd` out 1: read strobe to the ROM.
- `rom_addr` out `ADDR_W`: byte address for `rom_rd`.
- `rom_data` in 8: read data. Valid exactly one cycle after the cycle in which `rom_rd`=1.
- `instr` out 32: head bytes. `[7:0]` holds the opcode at `pc`, `[15:8]` holds `pc+1`, and so on. Bytes at or beyond `avail` are don't-care and driven 0.
- `avail` out 3: number of valid head bytes, saturating at 4.
- `pc` out `ADDR_W`: address of `instr[7:0]`.
- `consume` in 1: decode pops an instruction this cycle.
- `isize` in 2: instruction length minus 1. Encoding 0..3 means 1..4 bytes.
- `redirect` in 1: flush and refetch.
- `target` in `ADDR_W`: new `pc` when `redirect`=1.

## Operation
- **State**
  - `fptr`: next fetch address.
  - `pc`.
  - `count`: buffered bytes, 0..`DEPTH`.
  - `rd_ptr` and `wr_ptr`: buffer indices, `$clog2(DEPTH)` bits, wrapping mod `DEPTH`.
  - `inflight`: 1 if a ROM response arrives this cycle.
  - `drop`: 1 if that response must be discarded.
- **Issue**
  - `rom_rd` = `!rst` && (`count` + `inflight` < `DEPTH`). The check is conservative and ignores a pop in the same cycle.
  - `rom_addr` = `fptr`. `fptr` increments on each issue.
- **Response**
  - When `inflight` && `!drop`: `rom_data` is written at `wr_ptr`, then `wr_ptr`++ and `count`++.
- **Pop**
  - Legal only when `consume` && `avail` ≥ `isize`+1. Then `rd_ptr`, `pc` and `count` all advance by `isize`+1.
  - An illegal consume (too few bytes) is ignored: no state change.
- **Simultaneous push and pop**
  - `count` changes by (push ? 1 : 0) − (pop ? `isize`+1 : 0).
  - Writes never overwrite unread bytes.
- **Redirect** (has priority over consume and response)
  - `count`, `rd_ptr` and `wr_ptr` go to 0.
  - `pc` and `fptr` load `target`.
  - A read issued in the redirect cycle still completes, but its response is discarded (`drop`=1).
- **Addresses**
  - `fptr` and `pc` wrap modulo 2^`ADDR_W`, e.g. 0xFFFF+1 = 0x0000.

## Timing
- **Reset values**
  - `rom_rd`=0, `rom_addr`=`RESET_VEC`, `pc`=`RESET_VEC`, `avail`=0, `instr`=0.
  - `count`, pointers, `inflight` and `drop` are all 0.
- **Startup**
  - First `rom_rd`=1 in the first cycle after `rst` deasserts.
- **Latency from issue**
  - Issue at cycle N, data at N+1, visible in `avail`/`instr` at N+2.
- **Redirect latency**
  - Redirect sampled at edge E.
  - `rom_addr`=`target` in the cycle after E.
  - `avail` ≥ 1 two cycles after E.
- **Throughput**
  - Sustains 1 byte/cycle when not full.
  - `avail`=4 at the earliest 5 cycles after redirect.
- **Outputs**
  - `instr`, `avail` and `pc` are registered or derived from registered state only (no comb path from `consume`), except as described under Configuration.
- **Reset mid-operation**
  - Asynchronously forces the reset values.
  - An in-flight ROM response after reset release is ignored (`inflight` cleared).

## Configuration
- **`RISC8_FETCH_BYPASS_EN` defined**
  - A valid, non-dropped response in the current cycle is forwarded combinationally into `instr` byte position `count` (when `count` < 4) and counted in `avail`.
  - Redirect-to-`avail` latency drops to one cycle.
  - If a pop covers the forwarded byte, the byte is not written to the buffer.
- **Undefined**
  - Pure registered behaviour as above.

## Structure
- Add to `risc8_pkg`:
  - `localparam FETCH_DEPTH = 8`.
  - `typedef logic [3:0][7:0] ibundle` (head bytes).
  - `localparam RESET_VEC = 0`.
- One sub-module, `risc8_fetch_buf`: circular byte buffer with a single push and a 1..4-byte pop, exposing head bytes and `count`.
- The top level holds the address/issue/redirect logic.

## Test plan
- **Reset and fill:** ROM[0..7]=0x10..0x17, no consume.
  - `rom_rd` in the first cycle after reset; `avail`=4, `instr`=0x13121110 at cycle 5.
  - `rom_rd` drops once `count`+`inflight`=8.
- **Mixed sizes:** consume with `isize`=0, then 3, then 1.
  - `pc` goes 0 → 1 → 5 → 7.
  - `instr[7:0]` is 0x11, then 0x15, then 0x17.
- **Illegal consume:** `avail`=2, `isize`=3 → no change to `pc` or `count`.
- **Redirect with a read in flight:** `target`=0x0040 in the cycle of `rom_rd` at 0x0009.
  - The byte from 0x0009 is never visible.
  - `pc`=0x0040, first `instr[7:0]`=ROM[0x40] two cycles later.
- **Wrap:** redirect to 0xFFFE.
  - `rom_addr` sequence is 0xFFFE, 0xFFFF, 0x0000.
  - A 4-byte pop moves `pc` to 0x0002.
- **Async reset mid-stream** with the buffer at `count`=6.
  - `avail`=0 and `pc`=`RESET_VEC` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/risc8_pkg.sv
// Shared risc8 core definitions: fetch buffer depth, reset vector and the
// head-byte bundle type passed from fetch to decode.
package risc8_pkg;

    localparam int          FETCH_DEPTH = 8;
    localparam logic [15:0] RESET_VEC   = 16'h0000;

    // [0] is the opcode byte, [1..3] the following immediates
    typedef logic [3:0][7:0] ibundle;

endpackage

// File: rtl/risc8_fetch_buf.sv
// Circular byte buffer for the risc8 prefetch stage: one byte push per cycle,
// 1..4 byte pop, head bytes beyond the buffered count read as zero.
module risc8_fetch_buf
    import risc8_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       store,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    input  logic [2:0]                 pop_n,
    output ibundle                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + AW'(pop_n);
            count <= count + CW'(push) - (pop ? CW'(pop_n) : '0);
        end
    end

    // store can be withheld for a byte that is consumed before it lands
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= push_data;
    end

    always_comb begin
        head = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (CW'(i) < count)
                head[i] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule

// File: rtl/risc8_fetch.sv
// risc8 instruction prefetch: issues ROM reads, fills the byte buffer and
// handles redirects. Define RISC8_FETCH_BYPASS_EN to forward ROM data into instr.
module risc8_fetch
    import risc8_pkg::*;
#(
    parameter int                DEPTH     = FETCH_DEPTH,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(risc8_pkg::RESET_VEC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [31:0]       instr,
    output logic [2:0]        avail,
    output logic [ADDR_W-1:0] pc,
    input  logic              consume,
    input  logic [1:0]        isize,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target
);

    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fptr;
    logic              inflight;
    logic              drop;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              fwd;
    logic              push;
    logic              store;
    logic              pop;
    logic [2:0]        pop_n;
    ibundle            head;
    ibundle            bundle;

    // Issue check counts the pending response but not a same-cycle pop
    assign occ      = {1'b0, count} + (CW+1)'(inflight);
    assign rom_rd   = !rst && (occ < (CW+1)'(DEPTH));
    assign rom_addr = fptr;

    assign fwd   = inflight && !drop;
    assign push  = fwd && !redirect;
    assign pop_n = {1'b0, isize} + 3'd1;
    assign pop   = consume && !redirect && (avail > {1'b0, isize});

    always_comb begin
        bundle = head;
        avail  = (count >= CW'(4)) ? 3'd4 : count[2:0];
        store  = push;
`ifdef RISC8_FETCH_BYPASS_EN
        if (fwd && count < CW'(4)) begin
            bundle[count[1:0]] = rom_data;
            avail              = count[2:0] + 3'd1;
        end
        // a pop reaching past the buffered bytes has eaten the forwarded one
        store = push && !(pop && CW'(pop_n) > count);
`endif
    end

    assign instr = bundle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fptr     <= RESET_VEC;
            pc       <= RESET_VEC;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= rom_rd;
            drop     <= redirect;
            if (redirect) begin
                fptr <= target;
                pc   <= target;
            end else begin
                fptr <= fptr + ADDR_W'(rom_rd);
                if (pop)
                    pc <= pc + ADDR_W'(pop_n);
            end
        end
    end

    risc8_fetch_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .store    (store),
        .push_data(rom_data),
        .pop      (pop),
        .pop_n    (pop_n),
        .head     (head),
        .count    (count)
    );

endmodule

// File: tb/tb_risc8_fetch.sv
// Bench for risc8_fetch: byte-queue reference model feeds a scoreboard that a
// separate monitor drains every cycle, plus directed checks on the key scenarios.
module tb_risc8_fetch;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [31:0] instr;
    logic [2:0]  avail;
    logic [15:0] pc;
    logic        consume;
    logic [1:0]  isize;
    logic        redirect;
    logic [15:0] target;

    int unsigned passed = 0;
    int unsigned total  = 0;

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [2:0]  avail;
        logic [31:0] instr;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] rom [65536];

    // reference model: bytes held in a plain queue, one outstanding read
    logic [7:0]  m_q [$];
    logic [15:0] m_pc;
    logic [15:0] m_fptr;
    logic [15:0] m_iaddr;
    logic        m_infl;
    logic        m_drop;

    risc8_fetch #(
        .DEPTH    (DEPTH),
        .ADDR_W   (16),
        .RESET_VEC(16'h0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rom_rd  (rom_rd),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .instr   (instr),
        .avail   (avail),
        .pc      (pc),
        .consume (consume),
        .isize   (isize),
        .redirect(redirect),
        .target  (target)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        rom_data <= rom_rd ? rom[rom_addr] : 8'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        m_q.delete();
        m_pc   = 16'h0000;
        m_fptr = 16'h0000;
        m_iaddr = 16'h0000;
        m_infl = 1'b0;
        m_drop = 1'b0;
    endtask

    // bytes decode can see this cycle, including a forwarded response
    function automatic int unsigned m_avail();
        int unsigned n;
        n = m_q.size();
`ifdef RISC8_FETCH_BYPASS_EN
        if (m_infl && !m_drop)
            n++;
`endif
        return (n > 4) ? 4 : n;
    endfunction

    task automatic step(input logic c, input logic [1:0] s, input logic r, input logic [15:0] t);
        exp_t        e;
        logic [7:0]  v [$];
        logic        resp;
        logic [7:0]  rb;
        int unsigned av;
        int unsigned n;
        consume  = c;
        isize    = s;
        redirect = r;
        target   = t;
        resp = m_infl && !m_drop;
        rb   = rom[m_iaddr];
        v    = m_q;
`ifdef RISC8_FETCH_BYPASS_EN
        if (resp)
            v.push_back(rb);
`endif
        av = m_avail();
        e  = '0;
        if (!rst) begin
            e.rd    = (m_q.size() + 32'(m_infl)) < DEPTH;
            e.addr  = m_fptr;
            e.pc    = m_pc;
            e.avail = 3'(av);
            for (int unsigned i = 0; i < av; i++)
                e.instr[8*i +: 8] = v[i];
        end
        sb.push_back(e);
        if (rst) begin
            m_reset();
        end else if (r) begin
            m_q.delete();
            m_pc    = t;
            m_iaddr = m_fptr;
            m_infl  = e.rd;
            m_drop  = 1'b1;
            m_fptr  = t;
        end else begin
            n = 32'(s) + 1;
            if (c && av >= n) begin
                repeat (n) void'(v.pop_front());
                m_pc = m_pc + 16'(n);
            end
`ifndef RISC8_FETCH_BYPASS_EN
            if (resp)
                v.push_back(rb);
`endif
            m_q     = v;
            m_infl  = e.rd;
            m_drop  = 1'b0;
            m_iaddr = m_fptr;
            m_fptr  = m_fptr + 16'(e.rd);
        end
        @(negedge clk);
    endtask

    // monitor: compares the DUT against whatever the model queued for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rom_rd",   32'(rom_rd),   32'(e.rd));
                chk("rom_addr", 32'(rom_addr), 32'(e.addr));
                chk("pc",       32'(pc),       32'(e.pc));
                chk("avail",    32'(avail),    32'(e.avail));
                chk("instr",    instr,         e.instr);
            end
        end
    end

    initial begin
        bit done;
        rst      = 1'b1;
        consume  = 1'b0;
        isize    = 2'd0;
        redirect = 1'b0;
        target   = 16'h0000;
        for (int i = 0; i < 65536; i++)
            rom[i] = 8'($urandom);
        for (int i = 0; i < 8; i++)
            rom[i] = 8'(8'h10 + i);
        rom[9]    = 8'hA5;
        rom[16'h40] = 8'h5A;
        m_reset();

        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;

        // reset and fill
        for (int k = 0; k < 5; k++)
            step(0, 0, 0, 0);
        chk("fill_avail4", 32'(avail), 32'd4);
        chk("fill_instr",  instr, 32'h13121110);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (m_q.size() + 32'(m_infl) >= DEPTH)
                done = 1;
            else
                step(0, 0, 0, 0);
        end
        chk("fill_timeout", 32'(done), 32'd1);
        chk("fill_rd_stop", 32'(rom_rd), 32'd0);

        // mixed sizes
        step(1, 0, 0, 0);
        chk("mix_pc1", 32'(pc), 32'h1);
        chk("mix_b1",  32'(instr[7:0]), 32'h11);
        step(1, 3, 0, 0);
        chk("mix_pc5", 32'(pc), 32'h5);
        chk("mix_b5",  32'(instr[7:0]), 32'h15);
        step(1, 1, 0, 0);
        chk("mix_pc7", 32'(pc), 32'h7);
        chk("mix_b7",  32'(instr[7:0]), 32'h17);

        // redirect while the read of 0x0009 is in flight
        step(0, 0, 1, 16'h0004);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            if ((m_q.size() + 32'(m_infl)) < DEPTH && m_fptr == 16'h0009)
                done = 1;
            else
                step(0, 0, 0, 0);
        end
        chk("rd9_timeout", 32'(done), 32'd1);
        step(0, 0, 1, 16'h0040);
        chk("redir_addr", 32'(rom_addr), 32'h40);
        chk("redir_pc",   32'(pc), 32'h40);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("redir_avail", 32'(avail != 3'd0), 32'd1);
        chk("redir_byte",  32'(instr[7:0]), 32'h5A);

        // illegal consume
        step(0, 0, 1, 16'h0100);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (m_avail() == 2)
                done = 1;
            else
                step(0, 0, 0, 0);
        end
        chk("illegal_timeout", 32'(done), 32'd1);
        step(1, 3, 0, 0);
        chk("illegal_pc", 32'(pc), 32'h100);

        // address wrap
        step(0, 0, 1, 16'hFFFE);
        chk("wrap_a0", 32'(rom_addr), 32'hFFFE);
        step(0, 0, 0, 0);
        chk("wrap_a1", 32'(rom_addr), 32'hFFFF);
        step(0, 0, 0, 0);
        chk("wrap_a2", 32'(rom_addr), 32'h0000);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (m_avail() == 4)
                done = 1;
            else
                step(0, 0, 0, 0);
        end
        chk("wrap_timeout", 32'(done), 32'd1);
        step(1, 3, 0, 0);
        chk("wrap_pc", 32'(pc), 32'h0002);

        // asynchronous reset with six bytes buffered
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (m_q.size() == 6)
                done = 1;
            else
                step(0, 0, 0, 0);
        end
        chk("six_timeout", 32'(done), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_avail", 32'(avail),  32'd0);
        chk("arst_pc",    32'(pc),     32'h0000);
        chk("arst_instr", instr,       32'h0);
        chk("arst_rd",    32'(rom_rd), 32'd0);
        m_reset();
        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            logic [15:0] t;
            t = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0), t);
        end
        step(0, 0, 0, 0);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
